// File: rtl/hex_quad_seg7_driver.sv
// Quad 7-segment driver fed by one 32-bit PIO word: hex font, per-digit enable,
// blink, leading-zero blanking, PWM brightness and a live display-hold bit.
module hex_quad_seg7_driver #(
  parameter int CLK_HZ     = 50000000,
  parameter int BLINK_HZ   = 2,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] data_in,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic        blink_phase
);

  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int CNT_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);
  localparam logic [6:0] BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;

  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] seg;
    case (n)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
    endcase
    return ACTIVE_LOW ? ~seg : seg;
  endfunction

  logic [28:0]      shd_p1_q, shd_p1_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic [3:0]       pwm_cnt_q, pwm_cnt_d;
  logic [3:0][6:0]  hex_p2_q, hex_p2_d;

  logic [3:0][3:0]  dig;
  logic [3:0]       en, blink, bright, lzb_blank;
  logic             lzb, pwm_on, lit;

  // Bits 31:30 are reserved and intentionally ignored.
  logic unused_rsvd;
  assign unused_rsvd = ^data_in[31:30];

  // Stage 1: shadow register, frozen while the hold bit is set on the live word
  always_comb begin
    shd_p1_d = data_in[29] ? shd_p1_q : data_in[28:0];
  end

  always_comb begin
    blink_cnt_d   = blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
    pwm_cnt_d = pwm_cnt_q + 4'd1;
  end

  // Stage 2: segment decode from the shadow word and current counter values
  always_comb begin
    for (int i = 0; i < 4; i++) dig[i] = shd_p1_q[4*i +: 4];
    en     = shd_p1_q[19:16];
    blink  = shd_p1_q[23:20];
    bright = shd_p1_q[27:24];
    lzb    = shd_p1_q[28];
    pwm_on = (bright == 4'hF) | (pwm_cnt_q < bright);

    // Digit 0 is never blanked so an all-zero value still shows "0".
    lzb_blank[3] = lzb & (dig[3] == 4'h0);
    lzb_blank[2] = lzb_blank[3] & (dig[2] == 4'h0);
    lzb_blank[1] = lzb_blank[2] & (dig[1] == 4'h0);
    lzb_blank[0] = 1'b0;

    lit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lit = en[i] & ~(blink[i] & blink_phase_q) & ~lzb_blank[i] & pwm_on;
      hex_p2_d[i] = lit ? font(dig[i]) : BLANK;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shd_p1_q      <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      pwm_cnt_q     <= '0;
      hex_p2_q      <= {4{BLANK}};
    end else begin
      shd_p1_q      <= shd_p1_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      pwm_cnt_q     <= pwm_cnt_d;
      hex_p2_q      <= hex_p2_d;
    end
  end

  assign hex0        = hex_p2_q[0];
  assign hex1        = hex_p2_q[1];
  assign hex2        = hex_p2_q[2];
  assign hex3        = hex_p2_q[3];
  assign blink_phase = blink_phase_q;

endmodule

// File: tb/tb_hex_quad_seg7_driver.sv
// Scoreboard bench for hex_quad_seg7_driver: stimulus pushes per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_hex_quad_seg7_driver;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] data_in = 32'hFFFF_FFFF;
  logic [6:0]  hex0, hex1, hex2, hex3;
  logic        blink_phase;

  hex_quad_seg7_driver #(.CLK_HZ(8), .BLINK_HZ(1), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [27:0] hex;   // {hex3,hex2,hex1,hex0}
    logic        bp;
    bit          chk_hex;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   k = 0;          // clock edges since the last reset release

  // blink_phase after k edges with BLINK_DIV=4 is (k/4)%2.
  task automatic push(input string nm, input logic [27:0] h, input bit chk);
    exp_t e;
    e.nm = nm; e.hex = h; e.bp = ((k / 4) % 2) != 0; e.chk_hex = chk;
    sb.push_back(e);
  endtask

  task automatic step(input string nm, input logic [27:0] h, input bit chk);
    @(posedge clk); k++; #1;
    push(nm, h, chk);
  endtask

  task automatic rstep(input string nm);
    @(posedge clk); #1;
    push(nm, {4{7'h7F}}, 1'b1);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      checks++;
      if (blink_phase !== cur.bp) begin
        errors++;
        $display("FAIL %s blink_phase: got %0b expected %0b (t=%0t)", cur.nm, blink_phase, cur.bp, $time);
      end
      if (cur.chk_hex) begin
        checks++;
        if ({hex3, hex2, hex1, hex0} !== cur.hex)
        begin
          errors++;
          $display("FAIL %s hex3..0: got %h %h %h %h expected %h %h %h %h (t=%0t)",
                   cur.nm, hex3, hex2, hex1, hex0,
                   cur.hex[27:21], cur.hex[20:14], cur.hex[13:7], cur.hex[6:0], $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  logic [6:0] h0, hp;

  initial begin
    // Reset with every field set: outputs blank, phase 0
    k = 0;
    for (int i = 0; i < 3; i++) rstep("reset");
    reset_n = 1'b1;
    step("rst_rel", {4{7'h7F}}, 1'b1);

    // Decode 1234
    data_in = 32'h0F0F_1234;
    step("dec_lat", '0, 1'b0);
    for (int i = 0; i < 32; i++) step("decode", {7'h79, 7'h24, 7'h30, 7'h19}, 1'b1);

    // Blink on digit 0 only
    data_in = 32'h0F1F_ABCD;
    step("blk_lat", '0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      h0 = ((k / 4) % 2) != 0 ? 7'h7F : 7'h21;
      step("blink", {7'h08, 7'h03, 7'h46, h0}, 1'b1);
    end

    // Leading-zero blanking and digit enable
    data_in = 32'h1F0F_0005;
    step("lzb_lat", '0, 1'b0);
    for (int i = 0; i < 8; i++) step("lzb_0005", {7'h7F, 7'h7F, 7'h7F, 7'h12}, 1'b1);
    data_in = 32'h1F0E_0000;
    step("lzb_lat", '0, 1'b0);
    for (int i = 0; i < 8; i++) step("lzb_en_off", {4{7'h7F}}, 1'b1);
    data_in = 32'h0F0E_0000;
    step("en_lat", '0, 1'b0);
    for (int i = 0; i < 8; i++) step("en_nolzb", {7'h40, 7'h40, 7'h40, 7'h7F}, 1'b1);

    // PWM: bright 4 lit while the pre-edge pwm count (k%16 before the step) < 4
    data_in = 32'h040F_8888;
    step("pwm_lat", '0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      hp = ((k % 16) < 4) ? 7'h00 : 7'h7F;
      step("pwm4", {4{hp}}, 1'b1);
    end
    data_in = 32'h000F_8888;
    step("pwm_lat", '0, 1'b0);
    for (int i = 0; i < 16; i++) step("pwm0", {4{7'h7F}}, 1'b1);
    data_in = 32'h0F0F_8888;
    step("pwm_lat", '0, 1'b0);
    for (int i = 0; i < 16; i++) step("pwmF", {4{7'h00}}, 1'b1);

    // Hold
    data_in = 32'h0F0F_1111;
    step("hold_lat", '0, 1'b0);
    for (int i = 0; i < 4; i++) step("hold_load", {4{7'h79}}, 1'b1);
    data_in = 32'h2F0F_2222;
    for (int i = 0; i < 8; i++) step("hold_on", {4{7'h79}}, 1'b1);
    data_in = 32'h0F0F_3333;
    step("hold_lat", '0, 1'b0);
    for (int i = 0; i < 8; i++) step("hold_off", {4{7'h30}}, 1'b1);

    // Mid-run reset (asserted between edges) restarts both counters
    step("pre_rst", {4{7'h30}}, 1'b1);
    @(negedge clk); #1;
    reset_n = 1'b0;
    data_in = 32'h040F_8888;
    k = 0;
    for (int i = 0; i < 3; i++) rstep("mid_reset");
    reset_n = 1'b1;
    step("mid_rel", {4{7'h7F}}, 1'b1);
    for (int i = 0; i < 32; i++) begin
      hp = ((k % 16) < 4) ? 7'h00 : 7'h7F;
      step("pwm_restart", {4{hp}}, 1'b1);
    end

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
